// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control path and its status/display logic.
// State encodings are fixed because the status LEDs decode them directly.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_t;

  // The counter chain advances in RUN and LAP; LAP only freezes the displays.
  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioning: two-flop synchronizer, stable-sample debounce counter
// and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      // Any sample that agrees with the current level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/reset controller between the push-buttons and the counter chain.
// Gates the hundredths tick into inc and produces the chain clear and display hold.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       tick_in,
  output logic       inc,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state
);

  logic      ss_level;
  logic      lr_level;
  logic      ss_press;
  logic      lr_press;
  logic      unused_levels;
  sw_state_t cur;
  sw_state_t nxt;
  logic      clr_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_start_stop),
    .level   (ss_level),
    .press   (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_lap_reset),
    .level   (lr_level),
    .press   (lr_press)
  );

  assign unused_levels = ss_level ^ lr_level;

  // start/stop has priority; a coincident lap/reset press is dropped, not queued.
  always_comb begin
    nxt     = cur;
    clr_nxt = 1'b0;
    if (ss_press) begin
      nxt = is_counting(cur) ? ST_PAUSE : ST_RUN;
    end else if (lr_press) begin
      case (cur)
        ST_IDLE:  clr_nxt = 1'b1;
        ST_RUN:   nxt = ST_LAP;
        ST_LAP:   nxt = ST_RUN;
        ST_PAUSE: begin
          nxt     = ST_IDLE;
          clr_nxt = 1'b1;
        end
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur  <= ST_IDLE;
      inc  <= 1'b0;
      clr  <= 1'b0;
      hold <= 1'b0;
    end else begin
      cur  <= nxt;
      inc  <= tick_in & is_counting(cur);
      clr  <= clr_nxt;
      hold <= (nxt == ST_LAP);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomized
// run, all compared against a history-window reference model.
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       inc;
  logic       clr;
  logic       hold;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .tick_in        (tick_in),
    .inc            (inc),
    .clr            (clr),
    .hold           (hold),
    .state          (state)
  );

  always #5 clock = ~clock;

  // Reference model: raw and synchronized sample histories per button;
  // a level flips once the last D synchronized samples all disagree with it.
  logic [1:0]  m_state;
  logic        m_inc, m_clr, m_hold;
  logic [31:0] raw_h [2];
  logic [31:0] sync_h [2];
  logic        lvl [2];
  logic        lvl_d [2];

  task automatic model_edge();
    logic       raw [2];
    logic       ss, lr, sp;
    logic [1:0] nxt;
    raw[0] = btn_start_stop;
    raw[1] = btn_lap_reset;
    if (!reset) begin
      m_state = 2'b00; m_inc = 1'b0; m_clr = 1'b0; m_hold = 1'b0;
      for (int b = 0; b < 2; b++) begin
        raw_h[b] = '0; sync_h[b] = '0; lvl[b] = 1'b0; lvl_d[b] = 1'b0;
      end
      return;
    end
    ss = lvl[0] && !lvl_d[0];
    lr = lvl[1] && !lvl_d[1];
    m_inc = tick_in && (m_state == 2'b01 || m_state == 2'b11);
    m_clr = 1'b0;
    nxt = m_state;
    if (ss) begin
      nxt = (m_state == 2'b01 || m_state == 2'b11) ? 2'b10 : 2'b01;
    end else if (lr) begin
      if (m_state == 2'b00) m_clr = 1'b1;
      else if (m_state == 2'b01) nxt = 2'b11;
      else if (m_state == 2'b11) nxt = 2'b01;
      else begin nxt = 2'b00; m_clr = 1'b1; end
    end
    m_hold = (nxt == 2'b11);
    m_state = nxt;
    for (int b = 0; b < 2; b++) begin
      lvl_d[b] = lvl[b];
      sp = raw_h[b][1];
      raw_h[b] = {raw_h[b][30:0], raw[b]};
      sync_h[b] = {sync_h[b][30:0], sp};
      if ((sync_h[b] & MASK) == (lvl[b] ? 32'd0 : MASK)) lvl[b] = !lvl[b];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic press_button(input bit which);
    if (which) btn_lap_reset = 1'b1; else btn_start_stop = 1'b1;
    repeat (D + 4) step();
    if (which) btn_lap_reset = 1'b0; else btn_start_stop = 1'b0;
    repeat (D + 6) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({state, inc, clr, hold} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {state, inc, clr, hold});
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_in = (i % 5 == 0);
      step();
      checks++;
      if ({state, inc, clr, hold} !== {m_state, m_inc, m_clr, m_hold} || inc !== 1'b0) begin
        errors++;
        $display("FAIL idle_ticks cyc %0d: got %b want %b", i,
                 {state, inc, clr, hold}, {m_state, m_inc, m_clr, m_hold});
      end
    end
    tick_in = 1'b0;
  endtask

  task automatic test_start();
    btn_start_stop = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 6 || i == 7) begin
        checks++;
        if (state !== ((i == 7) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL start_latency edge %0d: got state %b want %b", i, state,
                   (i == 7) ? 2'b01 : 2'b00);
        end
      end
    end
    repeat (3) step();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    checks++;
    if (inc !== 1'b1) begin
      errors++;
      $display("FAIL start_inc_high: got %b want 1", inc);
    end
    step();
    checks++;
    if (inc !== 1'b0) begin
      errors++;
      $display("FAIL start_inc_width: got %b want 0", inc);
    end
    btn_start_stop = 1'b0;
    repeat (D + 6) step();
    checks++;
    if ({state, inc, clr, hold} !== {m_state, m_inc, m_clr, m_hold}) begin
      errors++;
      $display("FAIL start_model: got %b want %b", {state, inc, clr, hold},
               {m_state, m_inc, m_clr, m_hold});
    end
  endtask

  task automatic test_bounce();
    int changes;
    logic [1:0] prev;
    for (int r = 0; r < 5; r++) begin
      btn_start_stop = 1'b1;
      repeat (3) step();
      btn_start_stop = 1'b0;
      repeat (2) step();
      checks++;
      if (state !== 2'b01 || state !== m_state) begin
        errors++;
        $display("FAIL bounce_glitch rep %0d: got state %b want 01", r, state);
      end
    end
    changes = 0;
    prev = state;
    btn_start_stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn_start_stop = 1'b0;
      step();
      if (state !== prev) changes++;
      prev = state;
    end
    checks++;
    if (changes != 1 || state !== 2'b10) begin
      errors++;
      $display("FAIL bounce_hold: got %0d changes state %b want 1 changes state 10",
               changes, state);
    end
    press_button(1'b0);
  endtask

  task automatic test_lap();
    press_button(1'b1);
    checks++;
    if (state !== 2'b11 || hold !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: got state %b hold %b want 11 1", state, hold);
    end
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    checks++;
    if (inc !== 1'b1) begin
      errors++;
      $display("FAIL lap_inc: got %b want 1", inc);
    end
    press_button(1'b1);
    checks++;
    if (state !== 2'b01 || hold !== 1'b0) begin
      errors++;
      $display("FAIL lap_exit: got state %b hold %b want 01 0", state, hold);
    end
  endtask

  task automatic test_pause_clear();
    int clr_cycles;
    press_button(1'b0);
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL pause_enter: got state %b want 10", state);
    end
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    checks++;
    if (inc !== 1'b0) begin
      errors++;
      $display("FAIL pause_no_inc: got %b want 0", inc);
    end
    clr_cycles = 0;
    btn_lap_reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) btn_lap_reset = 1'b0;
      step();
      if (clr === 1'b1) clr_cycles++;
    end
    checks++;
    if (clr_cycles != 1 || state !== 2'b00) begin
      errors++;
      $display("FAIL pause_clear: got %0d clr cycles state %b want 1 and 00",
               clr_cycles, state);
    end
  endtask

  task automatic test_simultaneous();
    int clr_cycles;
    press_button(1'b0);
    clr_cycles = 0;
    btn_start_stop = 1'b1;
    btn_lap_reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin btn_start_stop = 1'b0; btn_lap_reset = 1'b0; end
      step();
      if (clr === 1'b1) clr_cycles++;
    end
    checks++;
    if (state !== 2'b10 || hold !== 1'b0 || clr_cycles != 0) begin
      errors++;
      $display("FAIL simultaneous: got state %b hold %b clr %0d want 10 0 0",
               state, hold, clr_cycles);
    end
    press_button(1'b0);
    press_button(1'b1);
    checks++;
    if (state !== 2'b11 || hold !== 1'b1) begin
      errors++;
      $display("FAIL lap_before_reset: got state %b hold %b want 11 1", state, hold);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if (state !== 2'b00 || hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_lap: got state %b hold %b want 00 0", state, hold);
    end
  endtask

  task automatic test_random();
    int left [2];
    left[0] = 0;
    left[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 2; b++) begin
        if (left[b] == 0) begin
          left[b] = $urandom_range(1, 12);
          if (b == 0) btn_start_stop = $urandom_range(0, 1) == 1;
          else btn_lap_reset = $urandom_range(0, 1) == 1;
        end
        left[b]--;
      end
      tick_in = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) != 0);
      step();
      checks++;
      if ({state, inc, clr, hold} !== {m_state, m_inc, m_clr, m_hold}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i, {state, inc, clr, hold},
                 {m_state, m_inc, m_clr, m_hold});
      end
    end
    tick_in = 1'b0;
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap_reset = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_start();
    test_bounce();
    test_lap();
    test_pause_clear();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
